hist_eq_ctrl: RTL and testbench

//  Sequences one histogram-equalisation frame: clears bins, counts pixels, builds the CDF and cdf_min,

---
 rtl/hist_eq_pkg.sv | 30 +++
 rtl/hist_eq_ctrl_if.sv | 25 ++
 rtl/hist_bin_ram.sv | 35 +++
 rtl/hist_eq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_hist_eq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation frame controller.
//   NPIX_DEFAULT : pixels per frame for a 320x240 image
//   BINS         : number of luma bins / LUT entries
//   CNT_W        : width of bin counts and CDF values
//   state_e      : controller FSM states
//   rd_op_e      : what to do with the bin-RAM word returning from last cycle's read
package hist_eq_pkg;

    localparam int NPIX_DEFAULT = 76800;
    localparam int BINS         = 256;
    localparam int CNT_W        = 17;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HIST,
        CDF,
        MAP
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,   // histogram increment
        OP_ACC,   // CDF accumulate and write back
        OP_MAP    // present CDF to datapath and write LUT
    } rd_op_e;

endpackage

// File: rtl/hist_eq_ctrl_if.sv
// Pixel stream and LUT write bus of the histogram-equalisation controller.
//   pix_valid / pix_ready / pix_in : decoded-pixel handshake (controller accepts)
//   lut_we / lut_addr / lut_data   : remap LUT write port (controller drives)
// master : the surrounding system (pixel source, LUT sink)
// slave  : the controller
interface hist_eq_ctrl_if;

    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_in;
    logic       lut_we;
    logic [7:0] lut_addr;
    logic [7:0] lut_data;

    modport master (
        output pix_valid, pix_in,
        input  pix_ready, lut_we, lut_addr, lut_data
    );

    modport slave (
        input  pix_valid, pix_in,
        output pix_ready, lut_we, lut_addr, lut_data
    );

endinterface

// File: rtl/hist_bin_ram.sv
// Bin RAM: BINS x CNT_W, one write port and one synchronous read port.
// A read concurrent with a write to the same address returns the old word;
// the controller forwards around that case.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (data valid the following cycle)
//   rdata : read data
module hist_bin_ram
    import hist_eq_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  cnt_t       wdata,
    input  logic [7:0] raddr,
    output cnt_t       rdata
);

    cnt_t mem [BINS];
    cnt_t rdata_q;

    // NOTE: the array and its read register have no reset so they map onto a RAM
    // macro; the controller clears every bin before it reads any.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hist_eq_ctrl.sv
// Histogram-equalisation frame controller.
// On start: clears the 256 bins, counts NPIX pixels into them, turns the bins
// into a CDF in place (latching the minimum nonzero CDF), then presents each
// CDF entry to the external hist_eq datapath and writes the clamped result to
// the remap LUT. A frame with every pixel in one bin writes the identity LUT.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a frame (only honoured in IDLE)
//   bus            : pixel handshake in, LUT write port out (hist_eq_ctrl_if.slave)
//   cdf_out        : CDF of the bin being mapped, to the datapath
//   cdf_min_out    : minimum nonzero CDF, to the datapath
//   eq_pxl_in      : datapath result for cdf_out
//   busy           : high outside IDLE
//   done           : one-cycle pulse after the last LUT write
//   frame_cycles   : cycles from start accept to done (only with HIST_EQ_PERF_EN)
// Build option: define HIST_EQ_PERF_EN to add the frame_cycles counter/port.
module hist_eq_ctrl
    import hist_eq_pkg::*;
#(
    parameter int NPIX = NPIX_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    hist_eq_ctrl_if.slave bus,
    output cnt_t          cdf_out,
    output cnt_t          cdf_min_out,
    input  logic [31:0]   eq_pxl_in,
    output logic          busy,
    output logic          done
`ifdef HIST_EQ_PERF_EN
    ,
    output logic [31:0]   frame_cycles
`endif
);

    localparam cnt_t NPIX_C  = cnt_t'(NPIX);
    localparam cnt_t NPIX_M1 = cnt_t'(NPIX - 1);

    state_e     state_q,     state_d;
    logic [8:0] cnt_q,       cnt_d;      // bin sweep index, 0..256
    cnt_t       pix_cnt_q,   pix_cnt_d;
    rd_op_e     rd_op_q,     rd_op_d;
    logic [7:0] rd_addr_q,   rd_addr_d;
    logic       wr_en_q,     wr_en_d;
    logic [7:0] wr_addr_q,   wr_addr_d;
    cnt_t       wr_data_q,   wr_data_d;
    cnt_t       acc_q,       acc_d;
    cnt_t       cdf_min_q,   cdf_min_d;
    logic       done_q,      done_d;

    logic       ram_we;
    logic [7:0] ram_waddr;
    cnt_t       ram_wdata;
    logic [7:0] ram_raddr;
    cnt_t       ram_rdata;
    cnt_t       rd_val;
    cnt_t       acc_new;
    logic [CNT_W:0] acc_sum;
    logic       pix_ready;
    logic       lut_we;
    logic [7:0] lut_addr;
    logic [7:0] lut_data;

    hist_bin_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The RAM returns the pre-write word when last cycle's read hit the address
    // being written that same cycle (back-to-back same-bin pixels, or the final
    // histogram write landing on bin 0 as the CDF sweep starts).
    assign rd_val = (wr_en_q && (wr_addr_q == rd_addr_q)) ? wr_data_q : ram_rdata;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pix_cnt_d = pix_cnt_q;
        rd_op_d   = OP_NONE;
        rd_addr_d = rd_addr_q;
        acc_d     = acc_q;
        cdf_min_d = cdf_min_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = rd_addr_q;
        ram_wdata = '0;
        ram_raddr = cnt_q[7:0];
        pix_ready = 1'b0;
        lut_we    = 1'b0;
        lut_addr  = '0;
        lut_data  = '0;
        cdf_out   = '0;
        acc_sum   = {1'b0, acc_q} + {1'b0, rd_val};
        acc_new   = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

        // Second stage: consume the word read last cycle.
        case (rd_op_q)
            OP_INC: begin
                ram_we    = 1'b1;
                ram_wdata = rd_val + cnt_t'(1);
            end
            OP_ACC: begin
                acc_d     = acc_new;
                ram_we    = 1'b1;
                ram_wdata = acc_new;
                if (cdf_min_q == '0 && acc_new != '0) begin
                    cdf_min_d = acc_new;
                end
            end
            OP_MAP: begin
                lut_we   = 1'b1;
                lut_addr = rd_addr_q;
                cdf_out  = rd_val;
                if (cdf_min_q == NPIX_C) begin
                    lut_data = rd_addr_q;         // single-bin frame: datapath would divide by zero
                end else if (rd_val == '0) begin
                    lut_data = '0;
                end else if (eq_pxl_in > 32'd255) begin
                    lut_data = 8'hFF;
                end else begin
                    lut_data = eq_pxl_in[7:0];
                end
            end
            default: ;
        endcase

        // First stage: sequencing and read issue.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    cnt_d     = '0;
                    pix_cnt_d = '0;
                    acc_d     = '0;
                    cdf_min_d = '0;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q[7:0];
                ram_wdata = '0;
                if (cnt_q == 9'd255) begin
                    state_d = HIST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            HIST: begin
                pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    rd_op_d   = OP_INC;
                    rd_addr_d = bus.pix_in;
                    ram_raddr = bus.pix_in;
                    pix_cnt_d = pix_cnt_q + cnt_t'(1);
                    if (pix_cnt_q == NPIX_M1) begin
                        state_d = CDF;
                        cnt_d   = '0;
                    end
                end
            end
            CDF, MAP: begin
                if (!cnt_q[8]) begin
                    rd_op_d   = (state_q == CDF) ? OP_ACC : OP_MAP;
                    rd_addr_d = cnt_q[7:0];
                    cnt_d     = cnt_q + 9'd1;
                end else if (state_q == CDF) begin
                    state_d = MAP;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_en_d   = ram_we;
        wr_addr_d = ram_waddr;
        wr_data_d = ram_wdata;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pix_cnt_q <= '0;
            rd_op_q   <= OP_NONE;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            acc_q     <= '0;
            cdf_min_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pix_cnt_q <= pix_cnt_d;
            rd_op_q   <= rd_op_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            acc_q     <= acc_d;
            cdf_min_q <= cdf_min_d;
            done_q    <= done_d;
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.lut_we    = lut_we;
    assign bus.lut_addr  = lut_addr;
    assign bus.lut_data  = lut_data;
    assign cdf_min_out   = cdf_min_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

`ifdef HIST_EQ_PERF_EN
    logic [31:0] fc_q, fc_d;

    // Loaded with 1 on the accept cycle and counting every busy cycle, so the
    // value in the done cycle is the start-to-done distance; held while IDLE.
    always_comb begin
        fc_d = fc_q;
        if (state_q == IDLE && start) begin
            fc_d = 32'd1;
        end else if (state_q != IDLE) begin
            fc_d = fc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_cycles = fc_q;
`endif

endmodule

// File: tb/tb_hist_eq_ctrl.sv
module tb_hist_eq_ctrl;
    import hist_eq_pkg::*;

    localparam int NP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] eq_pxl_in;
    cnt_t        cdf_out;
    cnt_t        cdf_min_out;
    logic        busy;
    logic        done;
`ifdef HIST_EQ_PERF_EN
    logic [31:0] frame_cycles;
`endif

    hist_eq_ctrl_if bus ();

    hist_eq_ctrl #(.NPIX(NP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .cdf_out     (cdf_out),
        .cdf_min_out (cdf_min_out),
        .eq_pxl_in   (eq_pxl_in),
        .busy        (busy),
        .done        (done)
`ifdef HIST_EQ_PERF_EN
        ,
        .frame_cycles(frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference equalisation datapath: round((cdf-cdf_min)/(N-cdf_min)*255),
    // plus an optional bias that lets a frame push results past 255.
    int dp_bias = 0;

    function automatic int dp_fn(input int cdf, input int cmin);
        int den;
        den = NP - cmin;
        if (den <= 0 || cdf < cmin) return 0;
        return ((cdf - cmin) * 255 + den / 2) / den;
    endfunction

    always_comb eq_pxl_in = 32'(dp_fn(int'(cdf_out), int'(cdf_min_out)) + dp_bias);

    // Frame model
    int pix_arr [NP];
    int exp_lut [256];
    int exp_cdf [256];
    int exp_cmin;
    int cap_lut [256];
    int cap_cdf [256];
    int wr_cnt;
    int done_cnt;
    int exp_addr;

    task automatic build_model();
        int hist [256];
        int acc;
        for (int k = 0; k < 256; k++) hist[k] = 0;
        for (int i = 0; i < NP; i++) hist[pix_arr[i]]++;
        acc = 0;
        exp_cmin = 0;
        for (int k = 0; k < 256; k++) begin
            acc += hist[k];
            exp_cdf[k] = acc;
            if (exp_cmin == 0 && acc != 0) exp_cmin = acc;
        end
        for (int k = 0; k < 256; k++) begin
            if (exp_cmin == NP)       exp_lut[k] = k;
            else if (exp_cdf[k] == 0) exp_lut[k] = 0;
            else begin
                exp_lut[k] = dp_fn(exp_cdf[k], exp_cmin) + dp_bias;
                if (exp_lut[k] > 255) exp_lut[k] = 255;
            end
        end
        for (int k = 0; k < 256; k++) begin
            cap_lut[k] = -1;
            cap_cdf[k] = -1;
        end
        wr_cnt   = 0;
        done_cnt = 0;
        exp_addr = 0;
    endtask

    // Compare process: every LUT write is checked against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.lut_we) begin
                check("lut_addr", bus.lut_addr, exp_addr);
                check("lut_data", bus.lut_data, exp_lut[bus.lut_addr]);
                check("cdf_out", cdf_out, exp_cdf[bus.lut_addr]);
                check("cdf_min_out", cdf_min_out, exp_cmin);
                cap_lut[bus.lut_addr] = int'(bus.lut_data);
                cap_cdf[bus.lut_addr] = int'(cdf_out);
                wr_cnt++;
                exp_addr++;
            end
            if (done) begin
                done_cnt++;
                check("busy_with_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pix_ready"}, bus.pix_ready, 0);
        check({tag, "_lut_we"}, bus.lut_we, 0);
        check({tag, "_lut_addr"}, bus.lut_addr, 0);
        check({tag, "_lut_data"}, bus.lut_data, 0);
        check({tag, "_cdf_out"}, cdf_out, 0);
        check({tag, "_cdf_min_out"}, cdf_min_out, 0);
    endtask

    // mode 0: valid held, 1: valid toggles every cycle, 2: random 30% gaps
    task automatic send_pixels(input int mode, input int count, output int stalls, output bit ok);
        int i;
        int n;
        bit v;
        i = 0;
        n = 0;
        stalls = 0;
        ok = 1'b1;
        while (i < count) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = ($urandom_range(99) >= 30);
            endcase
            bus.pix_valid = v;
            bus.pix_in    = v ? 8'(pix_arr[i]) : 8'($urandom);
            if (bus.pix_ready) begin
                if (v) i++;
                else   stalls++;
            end
            n++;
            tick();
            if (n > 3000) begin
                ok = 1'b0;
                break;
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int bias, input bit spam);
        int stalls;
        bit ok;
        int n;
        dp_bias = bias;
        build_model();
        // pixels offered while idle must be ignored
        repeat (3) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = 8'($urandom);
            tick();
        end
        bus.pix_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_pix_ready", bus.pix_ready, 0);
        pulse_start();
        check("busy_after_start", busy, 1);
        if (spam) pulse_start();
        send_pixels(mode, NP, stalls, ok);
        check("pixel_timeout", ok, 1);
        n = 0;
        while (!done && n < 2000) begin
            start = spam && (n == 100 || n == 300);
            tick();
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
`ifdef HIST_EQ_PERF_EN
        check("frame_cycles", frame_cycles, 771 + NP + stalls);
`endif
        tick();
        tick();
        check("lut_writes", wr_cnt, 256);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        bit ok;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // ramp 0..15: LUT[k]=17k for k<16, 255 above
        for (int i = 0; i < NP; i++) pix_arr[i] = i;
        run_frame(0, 0, 1'b0);
        check("ramp_lut0", cap_lut[0], 0);
        check("ramp_lut1", cap_lut[1], 17);
        check("ramp_lut15", cap_lut[15], 255);
        check("ramp_lut100", cap_lut[100], 255);
        check("ramp_cdf5", cap_cdf[5], 6);

        // reset after 5 accepted pixels
        pulse_start();
        send_pixels(0, 5, stalls, ok);
        check("mid_hist_pixels", ok, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_hist_reset");
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NP; i++) pix_arr[i] = int'($urandom_range(255));
        run_frame(2, 0, 1'b0);

        // degenerate: all pixels 7 -> identity LUT
        for (int i = 0; i < NP; i++) pix_arr[i] = 7;
        run_frame(0, 0, 1'b0);
        check("degen_lut0", cap_lut[0], 0);
        check("degen_lut7", cap_lut[7], 7);
        check("degen_lut200", cap_lut[200], 200);
        check("degen_lut255", cap_lut[255], 255);

        // 3,3,200,200 with valid toggling
        for (int i = 0; i < NP; i++) pix_arr[i] = ((i % 4) < 2) ? 3 : 200;
        run_frame(1, 0, 1'b0);
        check("alt_cdf3", cap_cdf[3], 8);
        check("alt_cdf199", cap_cdf[199], 8);
        check("alt_cdf200", cap_cdf[200], 16);
        check("alt_lut2", cap_lut[2], 0);
        check("alt_lut200", cap_lut[200], 255);

        // dense same-bin bursts with start spam
        for (int i = 0; i < NP; i++) pix_arr[i] = int'($urandom_range(3));
        run_frame(0, 0, 1'b1);

        // datapath overshoot must clamp to 255
        for (int i = 0; i < NP; i++) pix_arr[i] = int'($urandom_range(15));
        run_frame(2, 200, 1'b1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NP; i++) pix_arr[i] = int'($urandom_range(255));
            run_frame(f, 0, f[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
